// File: rtl/countdown_timer.sv
// Down-counting lab timer: loads from switches, decrements once per prescaled tick
// under start/pause key control, stops at zero and shows the count on two 7-seg digits.
module countdown_timer #(
    parameter int N           = 6,
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    input  logic [N-1:0] load_val,
    input  logic         start_n,
    input  logic         pause_n,
    output logic [N-1:0] count,
    output logic         running,
    output logic         done,
    output logic [6:0]   HEX0,
    output logic [6:0]   HEX1
);

    localparam int          PW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [1:0]    start_sync, pause_sync;
    logic          start_prev, pause_prev;
    logic          start_p, pause_p;
    logic          tick;

    // Keys idle high: 2-flop sync, then a registered falling-edge pulse.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            start_sync <= 2'b11;
            pause_sync <= 2'b11;
            start_prev <= 1'b1;
            pause_prev <= 1'b1;
            start_p    <= 1'b0;
            pause_p    <= 1'b0;
        end else begin
            start_sync <= {start_sync[0], start_n};
            pause_sync <= {pause_sync[0], pause_n};
            start_prev <= start_sync[1];
            pause_prev <= pause_sync[1];
            start_p    <= start_prev & ~start_sync[1];
            pause_p    <= pause_prev & ~pause_sync[1];
        end
    end

    assign tick = (presc == PMAX);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            count <= '0;
            presc <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    count <= load_val;
                    presc <= '0;
                    if (start_p)
                        state <= (load_val == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick) begin
                        count <= count - N'(1);
                        if (count == N'(1))
                            state <= S_DONE;
                        else if (pause_p && !start_p)
                            state <= S_PAUSE;
                    end else if (pause_p && !start_p) begin
                        state <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start_p)
                        state <= S_IDLE;
                    else if (pause_p)
                        state <= S_RUN;
                end
                S_DONE: begin
                    count <= '0;
                    presc <= '0;
                    if (start_p)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign running = (state == S_RUN);
    assign done    = (state == S_DONE);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Widened so the decimal split works for any legal N.
    logic [31:0] cnt32;
    logic [3:0]  units, tens;
    assign cnt32 = 32'(count);
    assign units = 4'(cnt32 % 32'd10);
    assign tens  = 4'(cnt32 / 32'd10);
    assign HEX0  = seg7(units);
    assign HEX1  = seg7(tens);

endmodule

// File: tb/tb_countdown_timer.sv
// Scenario bench for countdown_timer with a 4-cycle tick; expected count steps are
// queued when stimulus is applied and popped as the DUT changes count.
module tb_countdown_timer;

    localparam int N = 6;
    localparam int T = 4;
    localparam logic [6:0] SEG0 = 7'b1000000;

    logic         CLOCK_50 = 1'b0;
    logic         reset_n  = 1'b0;
    logic [N-1:0] load_val = '0;
    logic         start_n  = 1'b1;
    logic         pause_n  = 1'b1;
    logic [N-1:0] count;
    logic         running, done;
    logic [6:0]   HEX0, HEX1;

    typedef struct { logic [N-1:0] cnt; int cyc; } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    countdown_timer #(.N(N), .TICK_CYCLES(T)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .load_val(load_val),
        .start_n(start_n), .pause_n(pause_n), .count(count),
        .running(running), .done(done), .HEX0(HEX0), .HEX1(HEX1)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_val = 6'd5;
        step(3);
        n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if ({running, done} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got run=%b done=%b want 0 0", running, done); end
        n_checks++; if ({HEX1, HEX0} !== {SEG0, SEG0}) begin n_fail++; $display("FAIL reset_hex: got %b %b want %b %b", HEX1, HEX0, SEG0, SEG0); end
        @(negedge CLOCK_50); reset_n = 1'b1;
        step(1);
        n_checks++; if (count !== 6'd5) begin n_fail++; $display("FAIL reset_release_load: got %0d want 5", count); end
    endtask

    task automatic test_display();
        load_val = 6'd63; step(1);
        n_checks++; if ({HEX1, HEX0} !== {7'b0000010, 7'b0110000}) begin n_fail++; $display("FAIL disp_63: got %b %b want 0000010 0110000", HEX1, HEX0); end
        load_val = 6'd47; step(1);
        n_checks++; if ({HEX1, HEX0} !== {7'b0011001, 7'b1111000}) begin n_fail++; $display("FAIL disp_47: got %b %b want 0011001 1111000", HEX1, HEX0); end
    endtask

    task automatic test_basic_run();
        logic [N-1:0] prev;
        exp_t e;
        load_val = 6'd5; step(1);
        start_n = 1'b0; step(3);
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL start_latency_early: got run=%b want 0", running); end
        step(1);
        n_checks++; if (running !== 1'b1 || count !== 6'd5) begin n_fail++; $display("FAIL run_entry: got run=%b count=%0d want 1 5", running, count); end
        start_n = 1'b1;
        for (int i = 1; i <= 5; i++) sb.push_back('{cnt: N'(5 - i), cyc: T * i});
        prev = count;
        for (int c = 1; c <= 20; c++) begin
            step(1);
            if (count !== prev) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL run_extra_step: got count=%0d at cycle %0d want no change", count, c);
                end else begin
                    e = sb.pop_front();
                    if (count !== e.cnt || c != e.cyc) begin
                        n_fail++; $display("FAIL run_step: got %0d at cycle %0d want %0d at cycle %0d", count, c, e.cnt, e.cyc);
                    end
                end
                prev = count;
            end
            if (c == 19) begin
                n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_early: got done=%b at cycle 19 want 0", done); end
            end
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL run_missing_steps: got %0d pending want 0", sb.size()); sb.delete(); end
        n_checks++; if ({done, running} !== 2'b10) begin n_fail++; $display("FAIL done_at_20: got done=%b run=%b want 1 0", done, running); end
        n_checks++; if ({HEX1, HEX0} !== {SEG0, SEG0}) begin n_fail++; $display("FAIL done_hex: got %b %b want %b %b", HEX1, HEX0, SEG0, SEG0); end
    endtask

    task automatic test_done_restart();
        step(3);
        start_n = 1'b0; step(4); start_n = 1'b1;
        n_checks++; if ({done, running} !== 2'b00) begin n_fail++; $display("FAIL done_to_idle: got done=%b run=%b want 0 0", done, running); end
        step(1);
        n_checks++; if (count !== 6'd5) begin n_fail++; $display("FAIL idle_reload: got %0d want 5", count); end
        step(2);
    endtask

    task automatic test_zero_load();
        bit ever_run = 0;
        load_val = 6'd0; step(1);
        start_n = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step(1);
            if (running) ever_run = 1;
            if (c == 3) begin
                n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_early: got done=%b want 0", done); end
            end
        end
        start_n = 1'b1;
        n_checks++; if (done !== 1'b1 || count !== 6'd0) begin n_fail++; $display("FAIL zero_done: got done=%b count=%0d want 1 0", done, count); end
        n_checks++; if (ever_run !== 1'b0) begin n_fail++; $display("FAIL zero_running: got ever_run=%b want 0", ever_run); end
        step(3);
        start_n = 1'b0; step(4); start_n = 1'b1; step(3);
    endtask

    task automatic test_pause_resume();
        bit held_ok = 1;
        exp_t e;
        load_val = 6'd10; step(1);
        start_n = 1'b0; step(4); start_n = 1'b1;
        sb.push_back('{cnt: 6'd9, cyc: 4});
        step(2);
        pause_n = 1'b0;
        step(2);
        e = sb.pop_front();
        n_checks++; if (count !== e.cnt) begin n_fail++; $display("FAIL pre_pause_step: got %0d want %0d", count, e.cnt); end
        step(2);
        n_checks++; if (running !== 1'b0 || count !== 6'd9) begin n_fail++; $display("FAIL pause_entry: got run=%b count=%0d want 0 9", running, count); end
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (count !== 6'd9 || running !== 1'b0) held_ok = 0;
        end
        n_checks++; if (held_ok !== 1'b1) begin n_fail++; $display("FAIL pause_hold: got count=%0d run=%b want frozen 9", count, running); end
        pause_n = 1'b1; step(3);
        pause_n = 1'b0; step(4); pause_n = 1'b1;
        n_checks++; if (running !== 1'b1 || count !== 6'd9) begin n_fail++; $display("FAIL resume: got run=%b count=%0d want 1 9", running, count); end
        sb.push_back('{cnt: 6'd8, cyc: 2});
        step(1);
        n_checks++; if (count !== 6'd9) begin n_fail++; $display("FAIL resume_early: got %0d want 9", count); end
        step(1);
        e = sb.pop_front();
        n_checks++; if (count !== e.cnt) begin n_fail++; $display("FAIL resume_step: got %0d want %0d", count, e.cnt); end
        // Abort from PAUSE at count 7
        step(1);
        pause_n = 1'b0; step(4); pause_n = 1'b1;
        n_checks++; if (running !== 1'b0 || count !== 6'd7) begin n_fail++; $display("FAIL pause_at_7: got run=%b count=%0d want 0 7", running, count); end
        load_val = 6'd12; step(3);
        start_n = 1'b0; step(4); start_n = 1'b1;
        n_checks++; if ({running, done} !== 2'b00) begin n_fail++; $display("FAIL abort_state: got run=%b done=%b want 0 0", running, done); end
        step(1);
        n_checks++; if (count !== 6'd12) begin n_fail++; $display("FAIL abort_reload: got %0d want 12", count); end
        step(2);
    endtask

    task automatic test_simultaneous();
        start_n = 1'b0; step(4); start_n = 1'b1;
        pause_n = 1'b0;
        step(3);
        n_checks++; if (running !== 1'b1 || count !== 6'd12) begin n_fail++; $display("FAIL tick_pause_before: got run=%b count=%0d want 1 12", running, count); end
        step(1);
        n_checks++; if ({running, done} !== 2'b00 || count !== 6'd11) begin n_fail++; $display("FAIL tick_pause: got run=%b done=%b count=%0d want 0 0 11", running, done, count); end
        pause_n = 1'b1; step(3);
        start_n = 1'b0; pause_n = 1'b0; step(4);
        start_n = 1'b1; pause_n = 1'b1;
        n_checks++; if ({running, done} !== 2'b00) begin n_fail++; $display("FAIL both_keys_pause: got run=%b done=%b want 0 0", running, done); end
        step(1);
        n_checks++; if (count !== 6'd12) begin n_fail++; $display("FAIL both_keys_reload: got %0d want 12", count); end
        step(3);
    endtask

    task automatic test_reset_mid_run();
        bit hit = 0;
        load_val = 6'd40; step(1);
        start_n = 1'b0; step(4); start_n = 1'b1;
        for (int c = 0; c < 40 && !hit; c++) begin
            step(1);
            if (count === 6'd37) hit = 1;
        end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL reach_37: got count=%0d want 37 within 40 cycles", count); end
        reset_n = 1'b0; #1;
        n_checks++; if (count !== 6'd0 || {running, done} !== 2'b00) begin n_fail++; $display("FAIL async_reset: got count=%0d run=%b done=%b want 0 0 0", count, running, done); end
        n_checks++; if ({HEX1, HEX0} !== {SEG0, SEG0}) begin n_fail++; $display("FAIL async_reset_hex: got %b %b want %b %b", HEX1, HEX0, SEG0, SEG0); end
        @(negedge CLOCK_50); reset_n = 1'b1;
        step(1);
        n_checks++; if (count !== 6'd40 || running !== 1'b0) begin n_fail++; $display("FAIL post_reset_load: got count=%0d run=%b want 40 0", count, running); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_display();
        test_basic_run();
        test_done_restart();
        test_zero_load();
        test_pause_resume();
        test_simultaneous();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Down-counting timer for the DE1-SoC lab board, the complement of the up-counter already in the lab. It loads an N-bit value from the switches, decrements it once per prescaled tick under start/pause key control, stops at zero with a `done` flag, and drives two decimal 7-segment digits. It sits directly at the board top level, fed by CLOCK_50, the switches and the KEY buttons.

## Interface
Parameters:
- `N`, 6: counter width; legal range 1..6, so the maximum displayed value is 63.
- `TICK_CYCLES`, 50_000_000: CLOCK_50 cycles per decrement (1 Hz); the bench overrides it to 4.

Ports:
- `CLOCK_50`  in  1  50 MHz system clock.
- `reset_n`  in  1  asynchronous, active-low reset; clock is CLOCK_50.
- `load_val`  in  N  start value (SW[N-1:0]); treated as quasi-static, not synchronized.
- `start_n`  in  1  start/abort key, active-low, asynchronous (KEY0).
- `pause_n`  in  1  pause/resume key, active-low, asynchronous (KEY1).
- `count`  out  N  current count value.
- `running`  out  1  high in the RUN state.
- `done`  out  1  high in the DONE state.
- `HEX0`  out  7  units digit, active-low segments, bit6=g … bit0=a.
- `HEX1`  out  7  tens digit, same encoding.

## Operation
**Key conditioning**
- Each key passes through a 2-flop synchronizer, then a falling-edge detector.
- Each press produces one 1-cycle pulse: `start_p` or `pause_p`.
- Synchronizer and edge-detector flops reset to 1 (key released).
- A held key produces exactly one pulse.

**States:** IDLE, RUN, PAUSE, DONE. Reset enters IDLE.
- **IDLE:** `count <= load_val` every cycle; prescaler held at 0.
  - `start_p` with `load_val==0` → DONE.
  - `start_p` with `load_val!=0` → RUN.
  - `pause_p` is ignored.
- **RUN:** the prescaler counts 0..TICK_CYCLES-1 and wraps to 0.
  - A tick occurs on the cycle where the prescaler equals TICK_CYCLES-1; on a tick, `count <= count-1`.
  - If a tick makes `count` 0, go to DONE in the same edge.
  - `pause_p` → PAUSE; the prescaler value is retained.
  - `start_p` is ignored.
- **PAUSE:** `count` and the prescaler are frozen.
  - `pause_p` → RUN; the prescaler resumes from its held value.
  - `start_p` → IDLE (abort).
- **DONE:** `count` = 0.
  - `start_p` → IDLE.
  - `pause_p` is ignored.

**Outputs**
- `running` and `done` are decoded from the registered state.
- `count` is registered.
- Digits: `units = count % 10`, `tens = count / 10`.
- Segment patterns for 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Any other digit value shows blank (1111111).

**Boundary cases**
- `start_p` and `pause_p` in the same cycle: `start_p` has priority (acts in IDLE, PAUSE and DONE; is ignored in RUN, where `pause_p` is also suppressed that cycle).
- Tick and `pause_p` in the same RUN cycle: the decrement is applied, then the state goes to PAUSE, with the prescaler at 0.
- Tick that reaches 0 and `pause_p` together: the state goes to DONE.
- `count` never wraps below 0.

**Reset:** `reset_n` low at any time, including mid-RUN, immediately forces:
- state IDLE, `count` 0, prescaler 0, `running` 0, `done` 0;
- HEX0 and HEX1 both show "0".
- After release, IDLE loads `load_val` on the first clock edge.

## Timing
- Key latency: a key sampled low on edge k gives a `start_p`/`pause_p` pulse high after edge k+2. The state changes on edge k+3.
- First decrement in RUN occurs on the TICK_CYCLES-th edge after RUN entry.
- RUN entry to DONE, with no pauses: `load_val`×TICK_CYCLES edges.
- `done` rises on the same edge `count` becomes 0.
- Time spent in PAUSE adds exactly its duration; no tick is lost or duplicated.
- HEX outputs are combinational from `count`, with zero added latency.

## Test plan
- **Reset, basic run:** TICK_CYCLES=4, `load_val`=5, press start.
  - `running`=1; `count` steps 5,4,3,2,1,0, one step every 4 cycles.
  - `done`=1 exactly 20 cycles after RUN entry.
  - HEX1=HEX0=1000000.
- **Zero load:** `load_val`=0, press start → DONE 3 edges after the sampled press; `running` never asserts; `count`=0.
- **Pause mid-run:** `load_val`=10, run 6 cycles (`count`=9, prescaler=2), press pause and hold 20 cycles.
  - `count` stays 9 throughout.
  - After resume, the next decrement comes exactly 2 cycles after re-entering RUN.
- **Abort and restart:**
  - In PAUSE with `count`=7, press start → IDLE with `count`=`load_val`.
  - From DONE, press start → IDLE.
  - Simultaneous start+pause in PAUSE → IDLE.
- **Reset mid-run:** assert `reset_n`=0 at `count`=37 → `count`=0, `running`=0, `done`=0 with no clock edge; after release, IDLE with `count`=`load_val` on the next edge.
- **Display decode:** in IDLE with `load_val`=63 → HEX1=0000010, HEX0=0110000; with `load_val`=47 → HEX1=0011001, HEX0=1111000.
